mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences one instruction over 3-5 cycles.
//  Each cycle it drives every datapath mux select (mux_2to1/mux_3to1 sel lines) and every write enable.
//  Stalls on a memory ready handshake. Sits between the instruction register (op/funct) and the datapath.
// PARAMETERS
//  none. Widths are fixed by the ISA: op 6, funct 6, alu_control 3.
// PORTS
//  clk          in   1  single clock; all state changes on posedge
//  reset        in   1  asynchronous, active-high; state -> FETCH immediately
//  op           in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  zero         in   1  ALU zero flag (valid in BEQEX)
//  mem_ready    in   1  memory completes the current access this cycle
//  ir_write     out  1  load instruction register
//  pc_en        out  1  PC load = pc_write | (branch & zero)
//  mem_write    out  1  memory write strobe
//  reg_write    out  1  register file write
//  iord         out  1  addr mux: 0 = PC, 1 = ALUOut
//  mem_to_reg   out  1  WB mux: 0 = ALUOut, 1 = Data
//  reg_dst      out  1  dest mux: 0 = rt, 1 = rd
//  alu_src_a    out  1  0 = PC, 1 = A
//  alu_src_b    out  2  00 = B, 01 = 4, 10 = SignImm; 11 never driven
//  pc_src       out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target; 11 never driven
//  alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_op   out  1  one-cycle pulse when DECODE sees an unsupported opcode
// BEHAVIOUR
//  Moore FSM. Outputs are decoded from state. Only the memory-state enables are gated by mem_ready.
//  Reset: state = FETCH. All enables and illegal_op are 0 while reset is high.
//  On reset release, outputs are the FETCH values: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
//  FETCH : ir_write = pc_write = mem_ready. Hold in FETCH while !mem_ready. Else -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=10, add (branch target). Next state by op:
//          lw 6'h23 / sw 6'h2B -> MEMADR; R 6'h00 -> RTYPEEX; beq 6'h04 -> BEQEX;
//          addi 6'h08 -> ADDIEX (macro only); j 6'h02 -> JEX;
//          any other op -> FETCH, with illegal_op=1 for this cycle.
//  MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
//  MEMRD : iord=1. Hold while !mem_ready, else -> MEMWB.
//  MEMWB : reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  MEMWR : iord=1, mem_write=mem_ready. Hold while !mem_ready, else -> FETCH.
//  RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control from funct -> RTYPEWB.
//  RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  BEQEX : alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1 -> FETCH.
//  JEX   : pc_src=10, pc_write=1 -> FETCH.
//  alu_control: add for fetch/addr/addi; sub for beq.
//   R-type funct: 20 -> 010, 22 -> 110, 24 -> 000, 25 -> 001, 2A -> 111; other funct -> 010, no flag.
//  Latency with mem_ready=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//  An illegal op costs 2 cycles.
//  Reset asserted mid-instruction aborts it. No partial write-back follows the reset edge.
//  Unreachable state encodings -> FETCH.
// CONFIGURATION
//  MIPS_CTRL_ADDI_EN defined: op 6'h08 goes DECODE -> ADDIEX -> ADDIWB -> FETCH.
//   ADDIEX: alu_src_a=1, alu_src_b=10, add.
//   ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
//  Not defined: ADDI states are absent. op 6'h08 is illegal (illegal_op pulse, no register write).
// STRUCTURE
//  Package mips_ctrl_pkg holds:
//   - state_t enum
//   - OP_* opcode and FUNCT_* constants
//   - ALU_* 3-bit codes
//   - SRCB_*/PCSRC_* select encodings, shared with the datapath mux instances
//  Sub-module mips_alu_decoder: combinational (alu_op[1:0], funct) -> alu_control.
//   The FSM drives alu_op: 00 add, 01 sub, 10 funct.
//  FSM: one always_ff state register, plus one always_comb for next state and outputs.
// TESTING
//  1. reset mid-MEMRD (lw), release -> state FETCH, ir_write=0 during reset, iord=0 next cycle.
//  2. lw (op 23), mem_ready=1 -> 5 cycles; MEMWB has reg_write=1, mem_to_reg=1, reg_dst=0.
//  3. sw (op 2B), mem_ready low 3 cycles in MEMWR -> mem_write=0 for 3 cycles, then 1 for 1 cycle.
//     FETCH follows.
//  4. R-type funct 2A -> RTYPEEX alu_control=111; RTYPEWB reg_write=1, reg_dst=1.
//  5. beq with zero=1 -> pc_en=1, pc_src=01.
//     beq with zero=0 -> pc_en=0. j -> pc_src=10, pc_en=1.
//  6. op 08: with macro -> 4 cycles, reg_write in ADDIWB.
//     Without macro -> illegal_op=1 in DECODE, then FETCH, and reg_write never 1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and datapath muxes.
// MIPS_CTRL_ADDI_EN adds the addi execute/write-back states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
`ifdef MIPS_CTRL_ADDI_EN
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
`endif
    S_JEX     = 4'd9
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU control decode from FSM alu_op and R-type funct.
// Unknown funct falls back to add.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_ctl = ALU_ADD;
    unique case (1'b1)
      (funct == FUNCT_ADD): funct_ctl = ALU_ADD;
      (funct == FUNCT_SUB): funct_ctl = ALU_SUB;
      (funct == FUNCT_AND): funct_ctl = ALU_AND;
      (funct == FUNCT_OR):  funct_ctl = ALU_OR;
      (funct == FUNCT_SLT): funct_ctl = ALU_SLT;
      default:              funct_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      (alu_op == ALUOP_SUB):   alu_control = ALU_SUB;
      (alu_op == ALUOP_FUNCT): alu_control = funct_ctl;
      default:                 alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Define MIPS_CTRL_ADDI_EN to support addi (op 6'h08).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_en,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  state_t     state, next;
  logic [1:0] alu_op;
  logic       pc_write, branch;
  logic       ir_w, mem_w, reg_w, ill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next       = S_FETCH;
    ir_w       = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        alu_src_b = SRCB_4;
        ir_w      = mem_ready;
        pc_write  = mem_ready;
        next      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    next = S_MEMADR;
          (op == OP_RTYPE): next = S_RTYPEEX;
          (op == OP_BEQ):   next = S_BEQEX;
          (op == OP_J):     next = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          (op == OP_ADDI):  next = S_ADDIEX;
`endif
          default: begin
            next = S_FETCH;
            ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        next      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord  = 1'b1;
        mem_w = mem_ready;
        next  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        next      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_JEX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        next      = S_ADDIWB;
      end
      S_ADDIWB: reg_w = 1'b1;
`endif
      default: next = S_FETCH;
    endcase
  end

  // Enables are forced low while reset is held, even though FETCH is decoded
  assign ir_write   = ir_w & ~reset;
  assign mem_write  = mem_w & ~reset;
  assign reg_write  = reg_w & ~reset;
  assign illegal_op = ill & ~reset;
  assign pc_en      = (pc_write | (branch & zero)) & ~reset;

  mips_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl.
// Build with +define+MIPS_CTRL_ADDI_EN to cover the addi path.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       ir_write, pc_en, mem_write, reg_write, iord;
  logic       mem_to_reg, reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .iord        (iord),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_control (alu_control),
    .illegal_op  (illegal_op)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, ".ir_write"}, int'(ir_write), 1);
    chk({tag, ".pc_en"}, int'(pc_en), 1);
    chk({tag, ".iord"}, int'(iord), 0);
    chk({tag, ".srcb"}, int'(alu_src_b), 1);
    chk({tag, ".alu"}, int'(alu_control), 2);
    chk({tag, ".pcsrc"}, int'(pc_src), 0);
  endtask

  task automatic chk_decode(input string tag, input int ill);
    chk({tag, ".srcb"}, int'(alu_src_b), 2);
    chk({tag, ".srca"}, int'(alu_src_a), 0);
    chk({tag, ".alu"}, int'(alu_control), 2);
    chk({tag, ".ill"}, int'(illegal_op), ill);
    chk({tag, ".ir_write"}, int'(ir_write), 0);
  endtask

  initial begin
    reset = 1'b1;
    op = 6'h23; funct = 6'h00;
    zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst.ir_write", int'(ir_write), 0);
    chk("rst.pc_en", int'(pc_en), 0);
    chk("rst.reg_write", int'(reg_write), 0);
    chk("rst.ill", int'(illegal_op), 0);
    tick();
    reset = 1'b0;
    #1;
    chk_fetch("f0");

    // lw aborted by reset in MEMRD
    tick(); chk_decode("lw1.dec", 0);
    tick(); chk("lw1.madr.srca", int'(alu_src_a), 1);
    chk("lw1.madr.srcb", int'(alu_src_b), 2);
    tick(); chk("lw1.rd.iord", int'(iord), 1);
    #2 reset = 1'b1;
    #1;
    chk("lw1.rst.ir_write", int'(ir_write), 0);
    chk("lw1.rst.reg_write", int'(reg_write), 0);
    chk("lw1.rst.iord", int'(iord), 0);
    tick();
    chk("lw1.rsthold.reg_write", int'(reg_write), 0);
    #2 reset = 1'b0;
    #1;
    chk("lw1.post.iord", int'(iord), 0);
    chk_fetch("lw1.post");

    // full lw, 5 cycles
    tick(); chk_decode("lw2.dec", 0);
    tick(); chk("lw2.madr.srca", int'(alu_src_a), 1);
    tick(); chk("lw2.rd.iord", int'(iord), 1);
    chk("lw2.rd.reg_write", int'(reg_write), 0);
    tick(); chk("lw2.wb.reg_write", int'(reg_write), 1);
    chk("lw2.wb.m2r", int'(mem_to_reg), 1);
    chk("lw2.wb.rdst", int'(reg_dst), 0);
    tick(); chk_fetch("lw2.end");

    // sw with 3 stalled cycles in MEMWR
    op = 6'h2B;
    tick(); chk_decode("sw.dec", 0);
    tick(); chk("sw.madr.srcb", int'(alu_src_b), 2);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sw.stall%0d.mw", i), int'(mem_write), 0);
      chk($sformatf("sw.stall%0d.iord", i), int'(iord), 1);
      if (i < 2) tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw.go.mw", int'(mem_write), 1);
    tick(); chk("sw.end.mw", int'(mem_write), 0);
    chk_fetch("sw.end");

    // fetch stalls on memory
    mem_ready = 1'b0;
    #1;
    chk("fst.ir_write", int'(ir_write), 0);
    chk("fst.pc_en", int'(pc_en), 0);
    tick();
    chk("fst.hold.srcb", int'(alu_src_b), 1);
    mem_ready = 1'b1;
    #1;
    chk_fetch("fst.go");

    // R-type slt then or
    op = 6'h00; funct = 6'h2A;
    tick(); chk_decode("slt.dec", 0);
    tick(); chk("slt.ex.alu", int'(alu_control), 7);
    chk("slt.ex.srca", int'(alu_src_a), 1);
    chk("slt.ex.srcb", int'(alu_src_b), 0);
    tick(); chk("slt.wb.reg_write", int'(reg_write), 1);
    chk("slt.wb.rdst", int'(reg_dst), 1);
    chk("slt.wb.m2r", int'(mem_to_reg), 0);
    tick(); chk_fetch("slt.end");
    funct = 6'h25;
    tick(); tick(); chk("or.ex.alu", int'(alu_control), 1);
    funct = 6'h22; #1;
    chk("sub.ex.alu", int'(alu_control), 6);
    funct = 6'h3F; #1;
    chk("unk.ex.alu", int'(alu_control), 2);
    tick(); tick(); chk_fetch("r.end");

    // beq taken and not taken, then j
    op = 6'h04;
    tick(); chk_decode("beq.dec", 0);
    tick(); zero = 1'b1; #1;
    chk("beq.t.pc_en", int'(pc_en), 1);
    chk("beq.t.pcsrc", int'(pc_src), 1);
    chk("beq.t.alu", int'(alu_control), 6);
    zero = 1'b0; #1;
    chk("beq.nt.pc_en", int'(pc_en), 0);
    tick(); chk_fetch("beq.end");
    op = 6'h02;
    tick(); chk_decode("j.dec", 0);
    tick(); chk("j.pcsrc", int'(pc_src), 2);
    chk("j.pc_en", int'(pc_en), 1);
    chk("j.reg_write", int'(reg_write), 0);
    tick(); chk_fetch("j.end");

    // addi
    op = 6'h08;
`ifdef MIPS_CTRL_ADDI_EN
    tick(); chk_decode("addi.dec", 0);
    tick(); chk("addi.ex.srca", int'(alu_src_a), 1);
    chk("addi.ex.srcb", int'(alu_src_b), 2);
    chk("addi.ex.reg_write", int'(reg_write), 0);
    tick(); chk("addi.wb.reg_write", int'(reg_write), 1);
    chk("addi.wb.rdst", int'(reg_dst), 0);
    chk("addi.wb.m2r", int'(mem_to_reg), 0);
    tick(); chk_fetch("addi.end");
`else
    tick(); chk_decode("addi.dec", 1);
    chk("addi.dec.reg_write", int'(reg_write), 0);
    tick(); chk_fetch("addi.end");
    chk("addi.end.ill", int'(illegal_op), 0);
    chk("addi.end.reg_write", int'(reg_write), 0);
`endif

    // unsupported opcode
    op = 6'h3F;
    tick(); chk_decode("bad.dec", 1);
    tick(); chk_fetch("bad.end");
    chk("bad.end.ill", int'(illegal_op), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
